// File: rtl/reset_seq_pkg.sv
// Shared types for the staged reset sequencer: FSM state encoding, reset-cause
// codes reported to the BIOS, and a small helper used to size the counter.
package reset_seq_pkg;

    typedef enum logic [2:0] {
        ASSERT_ALL,
        WAIT_SDRAM,
        PERIPH_WAIT,
        CPU_WAIT,
        RUNNING,
        SOFT_HOLD,
        SDRAM_RETRY
    } state_t;

    typedef enum logic [1:0] {
        POWERON       = 2'b00,
        SOFTWARE      = 2'b01,
        DEBUG         = 2'b10,
        SDRAM_TIMEOUT = 2'b11
    } cause_t;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_sequencer.sv
// Staged reset distribution: releases SDRAM, then peripherals, then CPU with
// programmable gaps, turns software/debug requests into a warm reset that
// leaves the SDRAM running, and records the cause of the last reset.
//
// Optional feature: define RESET_SEQ_SDRAM_TIMEOUT_EN to bound the wait for
// sdram_config_done; on expiry the SDRAM controller is re-reset and retried.
module reset_sequencer #(
    parameter int PERIPH_DELAY     = 16,
    parameter int CPU_DELAY        = 16,
    parameter int SOFT_HOLD_CYCLES = 64,
    parameter int SDRAM_TIMEOUT    = 1000000
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       sdram_config_done,
    input  logic       sw_reset_req,
    input  logic       debug_reset_req,
    output logic       sdram_reset,
    output logic       periph_reset,
    output logic       cpu_reset,
    output logic       reset_in_progress,
    output logic [1:0] last_reset_cause
);
    import reset_seq_pkg::*;

`ifdef RESET_SEQ_SDRAM_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    // The timeout only widens the counter when the feature is built in.
    localparam int MAX_SPAN = max_of(max_of(PERIPH_DELAY, CPU_DELAY),
                                     max_of(SOFT_HOLD_CYCLES, TIMEOUT_EN ? SDRAM_TIMEOUT : 1));
    localparam int CNT_W    = (MAX_SPAN > 1) ? $clog2(MAX_SPAN) : 1;

    // Counter reload values: a stage of N cycles counts N-1 down to 0.
    localparam logic [CNT_W-1:0] PERIPH_LOAD = CNT_W'(PERIPH_DELAY - 1);
    localparam logic [CNT_W-1:0] CPU_LOAD    = CNT_W'(CPU_DELAY - 1);
    localparam logic [CNT_W-1:0] SOFT_LOAD   = CNT_W'(SOFT_HOLD_CYCLES - 1);
`ifdef RESET_SEQ_SDRAM_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(SDRAM_TIMEOUT - 1);
`endif

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             sdram_reset_reg, sdram_reset_next;
    logic             periph_reset_reg, periph_reset_next;
    logic             cpu_reset_reg, cpu_reset_next;
    logic             in_progress_reg, in_progress_next;
    cause_t           cause_reg, cause_next;

    // State, counter and all outputs are registered; reset forces everything asserted.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_reg        <= ASSERT_ALL;
            cnt_reg          <= '0;
            sdram_reset_reg  <= 1'b1;
            periph_reset_reg <= 1'b1;
            cpu_reset_reg    <= 1'b1;
            in_progress_reg  <= 1'b1;
            cause_reg        <= POWERON;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            sdram_reset_reg  <= sdram_reset_next;
            periph_reset_reg <= periph_reset_next;
            cpu_reset_reg    <= cpu_reset_next;
            in_progress_reg  <= in_progress_next;
            cause_reg        <= cause_next;
        end
    end

    // Next-state, counter and output decisions for the reset sequence.
    always_comb begin
        state_next        = state_reg;
        cnt_next          = cnt_reg;
        sdram_reset_next  = sdram_reset_reg;
        periph_reset_next = periph_reset_reg;
        cpu_reset_next    = cpu_reset_reg;
        in_progress_next  = in_progress_reg;
        cause_next        = cause_reg;

        case (state_reg)
            ASSERT_ALL: begin
                state_next       = WAIT_SDRAM;
                sdram_reset_next = 1'b0;
`ifdef RESET_SEQ_SDRAM_TIMEOUT_EN
                cnt_next         = TIMEOUT_LOAD;
`endif
            end

            WAIT_SDRAM: begin
                // A done flag on the expiry edge still counts as success.
                if (sdram_config_done) begin
                    state_next = PERIPH_WAIT;
                    cnt_next   = PERIPH_LOAD;
                end
`ifdef RESET_SEQ_SDRAM_TIMEOUT_EN
                else if (cnt_reg == '0) begin
                    state_next       = SDRAM_RETRY;
                    sdram_reset_next = 1'b1;
                    cause_next       = reset_seq_pkg::SDRAM_TIMEOUT;
                    cnt_next         = SOFT_LOAD;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
`endif
            end

            PERIPH_WAIT: begin
                if (cnt_reg == '0) begin
                    state_next        = CPU_WAIT;
                    periph_reset_next = 1'b0;
                    cnt_next          = CPU_LOAD;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end

            CPU_WAIT: begin
                if (cnt_reg == '0) begin
                    state_next       = RUNNING;
                    cpu_reset_next   = 1'b0;
                    in_progress_next = 1'b0;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end

            RUNNING: begin
                // Warm reset: SDRAM keeps running so its contents survive.
                if (sw_reset_req || debug_reset_req) begin
                    state_next        = SOFT_HOLD;
                    cpu_reset_next    = 1'b1;
                    periph_reset_next = 1'b1;
                    in_progress_next  = 1'b1;
                    cnt_next          = SOFT_LOAD;
                    cause_next        = debug_reset_req ? DEBUG : SOFTWARE;
                end
            end

            SOFT_HOLD: begin
                // SDRAM was never reset, so skip the config-done handshake.
                if (cnt_reg == '0) begin
                    state_next = PERIPH_WAIT;
                    cnt_next   = PERIPH_LOAD;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end

`ifdef RESET_SEQ_SDRAM_TIMEOUT_EN
            SDRAM_RETRY: begin
                if (cnt_reg == '0) begin
                    state_next       = WAIT_SDRAM;
                    sdram_reset_next = 1'b0;
                    cnt_next         = TIMEOUT_LOAD;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
`endif

            default: begin
                state_next = ASSERT_ALL;
            end
        endcase
    end

    assign sdram_reset       = sdram_reset_reg;
    assign periph_reset      = periph_reset_reg;
    assign cpu_reset         = cpu_reset_reg;
    assign reset_in_progress = in_progress_reg;
    assign last_reset_cause  = cause_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: each scenario pushes the expected
// output changes (edge number, outputs, cause) as it drives stimulus; a
// monitor records every actual output change, and the scenario compares them.
// Outputs are packed as {sdram_reset, periph_reset, cpu_reset, reset_in_progress}.
module tb_reset_sequencer;

    logic       sys_clk = 1'b0;
    logic       reset = 1'b1;
    logic       sdram_config_done = 1'b0;
    logic       sw_reset_req = 1'b0;
    logic       debug_reset_req = 1'b0;
    logic       sdram_reset, periph_reset, cpu_reset, reset_in_progress;
    logic [1:0] last_reset_cause;

    typedef struct {
        string      name;
        int         cyc;
        logic [3:0] outs;
        logic [1:0] cause;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    ev_t e_ev, o_ev;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    bit         mon_en = 1'b0;
    logic [5:0] prev;
    logic [3:0] outs_w;

    reset_sequencer #(
        .PERIPH_DELAY     (16),
        .CPU_DELAY        (16),
        .SOFT_HOLD_CYCLES (64),
        .SDRAM_TIMEOUT    (100)
    ) dut (
        .sys_clk           (sys_clk),
        .reset             (reset),
        .sdram_config_done (sdram_config_done),
        .sw_reset_req      (sw_reset_req),
        .debug_reset_req   (debug_reset_req),
        .sdram_reset       (sdram_reset),
        .periph_reset      (periph_reset),
        .cpu_reset         (cpu_reset),
        .reset_in_progress (reset_in_progress),
        .last_reset_cause  (last_reset_cause)
    );

    always #5 sys_clk = ~sys_clk;

    // Edge counter: at a negedge, cyc equals the number of rising edges so far.
    always @(posedge sys_clk) cyc <= cyc + 1;

    assign outs_w = {sdram_reset, periph_reset, cpu_reset, reset_in_progress};

    // Monitor: log every change of outputs or cause with the edge that caused it.
    always @(negedge sys_clk) begin
        if (mon_en && ({outs_w, last_reset_cause} !== prev))
            obs_q.push_back('{"obs", cyc, outs_w, last_reset_cause});
        prev <= {outs_w, last_reset_cause};
    end

    task automatic step(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic until_cyc(input int c);
        while (cyc < c) @(negedge sys_clk);
    endtask

    task automatic push_exp(input string n, input int c, input logic [3:0] o, input logic [1:0] k);
        exp_q.push_back('{n, c, o, k});
    endtask

    task automatic wait_obs(input int n, input int budget);
        int i;
        i = 0;
        while (obs_q.size() < n && i < budget) begin
            @(negedge sys_clk);
            i++;
        end
    endtask

    task automatic test_reset();
        int r, n;
        step(5);
        n_checks++;
        if (outs_w !== 4'b1111) begin
            n_fail++;
            $display("FAIL reset_outs: got %b, required 1111", outs_w);
        end else $display("ok   reset_outs: %b", outs_w);
        n_checks++;
        if (last_reset_cause !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_cause: got %b, required 00", last_reset_cause);
        end else $display("ok   reset_cause: %b", last_reset_cause);
        mon_en = 1'b1;
        step(1);
        reset = 1'b0;
        r = cyc + 1;
        push_exp("por_sdram_rel", r, 4'b0111, 2'b00);
        step(10);
        sdram_config_done = 1'b1;
        n = cyc + 1;
        push_exp("por_periph_rel", n + 16, 4'b0011, 2'b00);
        push_exp("por_cpu_rel", n + 32, 4'b0000, 2'b00);
        wait_obs(exp_q.size(), 500);
        while (exp_q.size() > 0) begin
            e_ev = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s: no output change seen, required cyc=%0d outs=%b cause=%b", e_ev.name, e_ev.cyc, e_ev.outs, e_ev.cause);
            end else begin
                o_ev = obs_q.pop_front();
                if (o_ev.cyc !== e_ev.cyc || o_ev.outs !== e_ev.outs || o_ev.cause !== e_ev.cause) begin
                    n_fail++;
                    $display("FAIL %s: got cyc=%0d outs=%b cause=%b, required cyc=%0d outs=%b cause=%b", e_ev.name, o_ev.cyc, o_ev.outs, o_ev.cause, e_ev.cyc, e_ev.outs, e_ev.cause);
                end else $display("ok   %s: cyc=%0d outs=%b cause=%b", e_ev.name, o_ev.cyc, o_ev.outs, o_ev.cause);
            end
        end
    endtask

    task automatic test_sw_reset();
        int m;
        step(3);
        sw_reset_req = 1'b1;
        m = cyc + 1;
        push_exp("sw_assert", m, 4'b0111, 2'b01);
        push_exp("sw_periph_rel", m + 80, 4'b0011, 2'b01);
        push_exp("sw_cpu_rel", m + 96, 4'b0000, 2'b01);
        step(1);
        sw_reset_req = 1'b0;
        wait_obs(exp_q.size(), 500);
        while (exp_q.size() > 0) begin
            e_ev = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s: no output change seen, required cyc=%0d outs=%b cause=%b", e_ev.name, e_ev.cyc, e_ev.outs, e_ev.cause);
            end else begin
                o_ev = obs_q.pop_front();
                if (o_ev.cyc !== e_ev.cyc || o_ev.outs !== e_ev.outs || o_ev.cause !== e_ev.cause) begin
                    n_fail++;
                    $display("FAIL %s: got cyc=%0d outs=%b cause=%b, required cyc=%0d outs=%b cause=%b", e_ev.name, o_ev.cyc, o_ev.outs, o_ev.cause, e_ev.cyc, e_ev.outs, e_ev.cause);
                end else $display("ok   %s: cyc=%0d outs=%b cause=%b", e_ev.name, o_ev.cyc, o_ev.outs, o_ev.cause);
            end
        end
    endtask

    task automatic test_back_to_back();
        int m;
        step(2);
        sw_reset_req    = 1'b1;
        debug_reset_req = 1'b1;
        m = cyc + 1;
        push_exp("both_assert", m, 4'b0111, 2'b10);
        push_exp("both_periph_rel", m + 80, 4'b0011, 2'b10);
        push_exp("both_cpu_rel", m + 96, 4'b0000, 2'b10);
        step(1);
        sw_reset_req    = 1'b0;
        debug_reset_req = 1'b0;
        // Extra requests during SOFT_HOLD and PERIPH_WAIT must be dropped.
        until_cyc(m + 9);
        sw_reset_req = 1'b1;
        step(1);
        sw_reset_req = 1'b0;
        until_cyc(m + 69);
        debug_reset_req = 1'b1;
        step(1);
        debug_reset_req = 1'b0;
        wait_obs(exp_q.size(), 500);
        step(5);
        while (exp_q.size() > 0) begin
            e_ev = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s: no output change seen, required cyc=%0d outs=%b cause=%b", e_ev.name, e_ev.cyc, e_ev.outs, e_ev.cause);
            end else begin
                o_ev = obs_q.pop_front();
                if (o_ev.cyc !== e_ev.cyc || o_ev.outs !== e_ev.outs || o_ev.cause !== e_ev.cause) begin
                    n_fail++;
                    $display("FAIL %s: got cyc=%0d outs=%b cause=%b, required cyc=%0d outs=%b cause=%b", e_ev.name, o_ev.cyc, o_ev.outs, o_ev.cause, e_ev.cyc, e_ev.outs, e_ev.cause);
                end else $display("ok   %s: cyc=%0d outs=%b cause=%b", e_ev.name, o_ev.cyc, o_ev.outs, o_ev.cause);
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL both_no_extra: got %0d unexpected output changes, required 0", obs_q.size());
            obs_q.delete();
        end else $display("ok   both_no_extra: 0 unexpected changes");
    endtask

    task automatic test_reset_mid();
        int m;
        step(2);
        sw_reset_req = 1'b1;
        m = cyc + 1;
        push_exp("mid_sw_assert", m, 4'b0111, 2'b01);
        step(1);
        sw_reset_req = 1'b0;
        // Hard reset lands in PERIPH_WAIT (entered at m+64, leaves at m+80).
        until_cyc(m + 69);
        reset = 1'b1;
        push_exp("mid_reset_assert", m + 70, 4'b1111, 2'b00);
        until_cyc(m + 72);
        reset = 1'b0;
        push_exp("mid_sdram_rel", m + 73, 4'b0111, 2'b00);
        push_exp("mid_periph_rel", m + 74 + 16, 4'b0011, 2'b00);
        push_exp("mid_cpu_rel", m + 74 + 32, 4'b0000, 2'b00);
        wait_obs(exp_q.size(), 500);
        while (exp_q.size() > 0) begin
            e_ev = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s: no output change seen, required cyc=%0d outs=%b cause=%b", e_ev.name, e_ev.cyc, e_ev.outs, e_ev.cause);
            end else begin
                o_ev = obs_q.pop_front();
                if (o_ev.cyc !== e_ev.cyc || o_ev.outs !== e_ev.outs || o_ev.cause !== e_ev.cause) begin
                    n_fail++;
                    $display("FAIL %s: got cyc=%0d outs=%b cause=%b, required cyc=%0d outs=%b cause=%b", e_ev.name, o_ev.cyc, o_ev.outs, o_ev.cause, e_ev.cyc, e_ev.outs, e_ev.cause);
                end else $display("ok   %s: cyc=%0d outs=%b cause=%b", e_ev.name, o_ev.cyc, o_ev.outs, o_ev.cause);
            end
        end
    endtask

    task automatic test_sdram_timeout();
        int r, n;
        step(2);
        sdram_config_done = 1'b0;
        reset = 1'b1;
        push_exp("to_reset_assert", cyc + 1, 4'b1111, 2'b00);
        step(3);
        reset = 1'b0;
        r = cyc + 1;
        push_exp("to_sdram_rel", r, 4'b0111, 2'b00);
`ifdef RESET_SEQ_SDRAM_TIMEOUT_EN
        push_exp("to_retry_assert", r + 100, 4'b1111, 2'b11);
        push_exp("to_retry_rel", r + 164, 4'b0111, 2'b11);
        until_cyc(r + 169);
        sdram_config_done = 1'b1;
        n = cyc + 1;
        push_exp("to_periph_rel", n + 16, 4'b0011, 2'b11);
        push_exp("to_cpu_rel", n + 32, 4'b0000, 2'b11);
`else
        until_cyc(r + 10000);
        n_checks++;
        if (outs_w !== 4'b0111) begin
            n_fail++;
            $display("FAIL to_wait_forever: got outs=%b, required 0111", outs_w);
        end else $display("ok   to_wait_forever: outs=%b", outs_w);
        n_checks++;
        if (obs_q.size() != 2) begin
            n_fail++;
            $display("FAIL to_no_retry: got %0d output changes, required 2", obs_q.size());
        end else $display("ok   to_no_retry: 2 output changes");
        sdram_config_done = 1'b1;
        n = cyc + 1;
        push_exp("to_periph_rel", n + 16, 4'b0011, 2'b00);
        push_exp("to_cpu_rel", n + 32, 4'b0000, 2'b00);
`endif
        wait_obs(exp_q.size(), 500);
        while (exp_q.size() > 0) begin
            e_ev = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s: no output change seen, required cyc=%0d outs=%b cause=%b", e_ev.name, e_ev.cyc, e_ev.outs, e_ev.cause);
            end else begin
                o_ev = obs_q.pop_front();
                if (o_ev.cyc !== e_ev.cyc || o_ev.outs !== e_ev.outs || o_ev.cause !== e_ev.cause) begin
                    n_fail++;
                    $display("FAIL %s: got cyc=%0d outs=%b cause=%b, required cyc=%0d outs=%b cause=%b", e_ev.name, o_ev.cyc, o_ev.outs, o_ev.cause, e_ev.cyc, e_ev.outs, e_ev.cause);
                end else $display("ok   %s: cyc=%0d outs=%b cause=%b", e_ev.name, o_ev.cyc, o_ev.outs, o_ev.cause);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sw_reset();
        test_back_to_back();
        test_reset_mid();
        test_sdram_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
